// File: rtl/move_engine.sv
// Sequential 2048 move engine: slides and merges an N x N board of exponent-coded
// tiles one line per clock, reporting moved / score increment / win on completion.
module move_engine #(
    parameter int N        = 4,
    parameter int TW       = 4,
    parameter int SCORE_W  = 16,
    parameter int WIN_CODE = 11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           dir,
    input  logic [N*N*TW-1:0]    board_in,
    output logic [N*N*TW-1:0]    board_out,
    output logic                 busy,
    output logic                 done,
    output logic                 moved,
    output logic [SCORE_W-1:0]   score_add,
    output logic                 win
);
    localparam int BW = N * N * TW;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [TW-1:0]    SAT_CODE  = '1;
    localparam logic [SCORE_W:0] SCORE_MAX = {1'b0, {SCORE_W{1'b1}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [1:0]         dir_q, dir_d;
    logic [BW-1:0]      work_q, work_d;
    logic [BW-1:0]      board_q, board_d;
    logic               moved_acc_q, moved_acc_d;
    logic               win_acc_q, win_acc_d;
    logic [SCORE_W-1:0] score_acc_q, score_acc_d;
    logic               moved_q, moved_d;
    logic               win_q, win_d;
    logic [SCORE_W-1:0] score_q, score_d;

    logic [TW-1:0]      line_in  [N];
    logic [TW-1:0]      comp     [N+1];
    logic [TW-1:0]      line_out [N];
    logic               line_moved;
    logic               line_win;
    logic [SCORE_W-1:0] line_score;

    // Bit offset of element j of line i, counted from the edge tiles slide toward.
    function automatic int tile_lsb(input logic [1:0] d, input int i, input int j);
        int r;
        int c;
        case (d)
            2'd0:    begin r = j;         c = i;         end
            2'd1:    begin r = N - 1 - j; c = i;         end
            2'd2:    begin r = i;         c = j;         end
            default: begin r = i;         c = N - 1 - j; end
        endcase
        return (N * N - 1 - (r * N + c)) * TW;
    endfunction

    // Line datapath: compact, merge adjacent equal pairs once, zero-fill the tail.
    always_comb begin
        int               k;
        int               o;
        logic             skip;
        logic [SCORE_W:0] sum;
        logic [SCORE_W:0] term;
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        k          = 0;
        o          = 0;
        skip       = 1'b0;
        term       = '0;
        sum        = {1'b0, score_acc_q};
        line_moved = 1'b0;
        line_win   = 1'b0;
        for (int j = 0; j <= N; j++) comp[j] = '0;
        for (int j = 0; j < N; j++) begin
            line_in[j]  = work_q[tile_lsb(dir_q, int'(idx_q), j) +: TW];
            line_out[j] = '0;
        end
        for (int j = 0; j < N; j++) begin
            if (line_in[j] != '0) begin
                comp[k] = line_in[j];
                k++;
            end
        end
        // comp[N] is always empty, so the pair test never matches past the last tile.
        for (int j = 0; j < N; j++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (comp[j] != '0) begin
                if (comp[j] == comp[j+1] && comp[j] != SAT_CODE) begin
                    line_out[o] = comp[j] + 1'b1;
                    term = (int'(comp[j]) + 1 >= SCORE_W) ? SCORE_MAX
                                                          : (SCORE_W+1)'(1) << (int'(comp[j]) + 1);
                    sum  = sum + term;
                    if (sum > SCORE_MAX) sum = SCORE_MAX;
                    skip = 1'b1;
                end else begin
                    line_out[o] = comp[j];
                end
                o++;
            end
        end
        for (int j = 0; j < N; j++) begin
            if (line_out[j] != line_in[j]) line_moved = 1'b1;
            if (int'(line_out[j]) >= WIN_CODE) line_win = 1'b1;
        end
        line_score = sum[SCORE_W-1:0];
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        dir_d       = dir_q;
        work_d      = work_q;
        board_d     = board_q;
        moved_acc_d = moved_acc_q;
        win_acc_d   = win_acc_q;
        score_acc_d = score_acc_q;
        moved_d     = moved_q;
        win_d       = win_q;
        score_d     = score_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_RUN;
                    idx_d       = '0;
                    dir_d       = dir;
                    work_d      = board_in;
                    moved_acc_d = 1'b0;
                    win_acc_d   = 1'b0;
                    score_acc_d = '0;
                end
            end
            S_RUN: begin
                for (int j = 0; j < N; j++) work_d[tile_lsb(dir_q, int'(idx_q), j) +: TW] = line_out[j];
                moved_acc_d = moved_acc_q | line_moved;
                win_acc_d   = win_acc_q | line_win;
                score_acc_d = line_score;
                if (idx_q == IW'(N - 1)) begin
                    state_d = S_DONE;
                    board_d = work_d;
                    moved_d = moved_acc_d;
                    win_d   = win_acc_d;
                    score_d = score_acc_d;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: the work register is cleared too, so an aborted move leaves no stale board behind.
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            dir_q       <= '0;
            work_q      <= '0;
            board_q     <= '0;
            moved_acc_q <= 1'b0;
            win_acc_q   <= 1'b0;
            score_acc_q <= '0;
            moved_q     <= 1'b0;
            win_q       <= 1'b0;
            score_q     <= '0;
        end else begin
            // NOTE: non-blocking updates keep every flop sampling the pre-edge values.
            state_q     <= state_d;
            idx_q       <= idx_d;
            dir_q       <= dir_d;
            work_q      <= work_d;
            board_q     <= board_d;
            moved_acc_q <= moved_acc_d;
            win_acc_q   <= win_acc_d;
            score_acc_q <= score_acc_d;
            moved_q     <= moved_d;
            win_q       <= win_d;
            score_q     <= score_d;
        end
    end

    assign board_out = board_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign moved     = moved_q;
    assign score_add = score_q;
    assign win       = win_q;
endmodule

// File: tb/tb_move_engine.sv
// Self-checking bench for move_engine: a 4x4 instance with wide score and a 3x3
// instance with a 4-bit score, checked against a queue-based reference model.
module tb_move_engine;
    typedef struct {
        logic [255:0] board;
        bit           moved;
        int           score;
        bit           win;
        int           cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    logic        start_a = 1'b0;
    logic [1:0]  dir_a = '0;
    logic [63:0] board_in_a = '0;
    logic [63:0] board_out_a;
    logic        busy_a, done_a, moved_a, win_a;
    logic [15:0] score_a;

    logic        start_b = 1'b0;
    logic [1:0]  dir_b = '0;
    logic [35:0] board_in_b = '0;
    logic [35:0] board_out_b;
    logic        busy_b, done_b, moved_b, win_b;
    logic [3:0]  score_b;

    exp_t        exp_a[$];
    exp_t        exp_b[$];
    exp_t        ea;
    exp_t        eb;
    int          bd[64];

    move_engine #(.N(4), .TW(4), .SCORE_W(16), .WIN_CODE(11)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .dir(dir_a), .board_in(board_in_a),
        .board_out(board_out_a), .busy(busy_a), .done(done_a), .moved(moved_a),
        .score_add(score_a), .win(win_a)
    );

    move_engine #(.N(3), .TW(4), .SCORE_W(4), .WIN_CODE(11)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .dir(dir_b), .board_in(board_in_b),
        .board_out(board_out_b), .busy(busy_b), .done(done_b), .moved(moved_b),
        .score_add(score_b), .win(win_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Flat row-major index of element j of line i, ordered from the destination edge.
    function automatic int pos(input int n, input int d, input int i, input int j);
        case (d)
            0:       return j * n + i;
            1:       return (n - 1 - j) * n + i;
            2:       return i * n + j;
            default: return i * n + (n - 1 - j);
        endcase
    endfunction

    function automatic logic [255:0] pack(input int n, input int b[64]);
        logic [255:0] v = '0;
        for (int p = 0; p < n * n; p++) v[(n*n-1-p)*4 +: 4] = 4'(b[p]);
        return v;
    endfunction

    // Reference move: gather non-empty tiles into a queue, then pop pairs off the front.
    task automatic model(input int n, input int scw, input int b[64], input int d,
                         output int r[64], output bit mv, output int sc, output bit w);
        int maxs;
        maxs = (1 << scw) - 1;
        sc = 0;
        mv = 1'b0;
        w  = 1'b0;
        foreach (r[p]) r[p] = 0;
        for (int i = 0; i < n; i++) begin
            int q[$];
            int o[$];
            for (int j = 0; j < n; j++) if (b[pos(n, d, i, j)] != 0) q.push_back(b[pos(n, d, i, j)]);
            while (q.size() > 0) begin
                int t;
                t = q.pop_front();
                if (q.size() > 0 && q[0] == t && t != 15) begin
                    void'(q.pop_front());
                    o.push_back(t + 1);
                    sc = sc + (1 << (t + 1));
                    if (sc > maxs) sc = maxs;
                end else begin
                    o.push_back(t);
                end
            end
            while (o.size() < n) o.push_back(0);
            for (int j = 0; j < n; j++) r[pos(n, d, i, j)] = o[j];
        end
        for (int p = 0; p < n * n; p++) begin
            if (r[p] != b[p]) mv = 1'b1;
            if (r[p] >= 11) w = 1'b1;
        end
    endtask

    // Compare process: every done pulse is matched against the oldest pending expectation.
    always @(negedge clk) begin
        if (done_a) begin
            check("a_done_expected", exp_a.size() > 0, 1);
            if (exp_a.size() > 0) begin
                ea = exp_a.pop_front();
                check("a_latency", cyc - ea.cyc, 5);
                check("a_board", board_out_a, ea.board);
                check("a_moved", moved_a, ea.moved);
                check("a_score", score_a, ea.score);
                check("a_win", win_a, ea.win);
            end
        end
        if (done_b) begin
            check("b_done_expected", exp_b.size() > 0, 1);
            if (exp_b.size() > 0) begin
                eb = exp_b.pop_front();
                check("b_latency", cyc - eb.cyc, 4);
                check("b_board", board_out_b, eb.board);
                check("b_moved", moved_b, eb.moved);
                check("b_score", score_b, eb.score);
                check("b_win", win_b, eb.win);
            end
        end
    end

    // Issues one move from a negedge and returns at a negedge after the done window.
    task automatic run_move(input bit sel, input int b[64], input int d, input bit poke);
        exp_t         e;
        int           r[64];
        bit           mv;
        bit           w;
        int           sc;
        int           n;
        int           ndone;
        int           bad_busy;
        logic [255:0] pk;
        n = sel ? 3 : 4;
        model(n, sel ? 4 : 16, b, d, r, mv, sc, w);
        e.board = pack(n, r);
        e.moved = mv;
        e.score = sc;
        e.win   = w;
        e.cyc   = cyc;
        pk = pack(n, b);
        if (sel) begin
            board_in_b = pk[35:0]; dir_b = 2'(d); start_b = 1'b1; exp_b.push_back(e);
        end else begin
            board_in_a = pk[63:0]; dir_a = 2'(d); start_a = 1'b1; exp_a.push_back(e);
        end
        ndone    = 0;
        bad_busy = 0;
        for (int t = 1; t <= n + 3; t++) begin
            @(negedge clk);
            if (t == 1 || t == 3) begin
                start_a = 1'b0; start_b = 1'b0;
                board_in_a = {$urandom, $urandom};
                board_in_b = 36'({$urandom, $urandom});
                dir_a = 2'($urandom); dir_b = 2'($urandom);
            end
            if (poke && t == 2) begin
                if (sel) start_b = 1'b1; else start_a = 1'b1;
            end
            if (sel) begin
                ndone += int'(done_b);
                if (busy_b != (t <= n + 1)) bad_busy++;
            end else begin
                ndone += int'(done_a);
                if (busy_a != (t <= n + 1)) bad_busy++;
            end
        end
        check(sel ? "b_done_once" : "a_done_once", ndone, 1);
        check(sel ? "b_busy_shape" : "a_busy_shape", bad_busy, 0);
    endtask

    task automatic clr();
        foreach (bd[p]) bd[p] = 0;
    endtask

    function automatic int rnd_tile();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 4) return 0;
        if (r < 8) return int'($urandom_range(1, 3));
        if (r == 8) return 15;
        return int'($urandom_range(10, 11));
    endfunction

    initial begin
        int ndone;
        repeat (3) @(negedge clk);
        check("rst_a_board", board_out_a, 0);
        check("rst_a_flags", {busy_a, done_a, moved_a, win_a}, 0);
        check("rst_a_score", score_a, 0);
        check("rst_b_board", board_out_b, 0);
        check("rst_b_flags", {busy_b, done_b, moved_b, win_b, score_b}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        clr(); bd[0] = 1; bd[1] = 1; bd[2] = 1; bd[3] = 1;
        run_move(1'b0, bd, 2, 1'b0);
        check("lit_left_board", board_out_a, 64'h2200_0000_0000_0000);
        check("lit_left_moved", moved_a, 1);
        check("lit_left_score", score_a, 8);

        clr(); bd[4] = 2; bd[6] = 2; bd[7] = 3;
        run_move(1'b0, bd, 3, 1'b0);
        check("lit_right_board", board_out_a, 64'h0000_0033_0000_0000);
        check("lit_right_score", score_a, 8);

        clr(); bd[0] = 15; bd[4] = 15;
        run_move(1'b0, bd, 0, 1'b0);
        check("lit_sat_up_board", board_out_a, 64'hF000_F000_0000_0000);
        check("lit_sat_up_flags", {moved_a, score_a}, 0);
        run_move(1'b0, bd, 1, 1'b0);
        check("lit_sat_down_board", board_out_a, 64'h0000_0000_F000_F000);
        check("lit_sat_down_moved", moved_a, 1);
        check("lit_sat_down_score", score_a, 0);

        clr(); bd[0] = 10; bd[1] = 10; bd[3] = 10; bd[4] = 10;
        run_move(1'b1, bd, 2, 1'b1);
        check("lit_clamp_board", board_out_b, 36'hB00_B00_000);
        check("lit_clamp_score", score_b, 15);
        check("lit_clamp_win", win_b, 1);

        // Abort a move with reset while line 2 is being processed.
        clr(); bd[0] = 3; bd[1] = 3;
        board_in_a = pack(4, bd)[63:0];
        dir_a = 2'd2; start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        @(negedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk);
        check("abort_board", board_out_a, 0);
        check("abort_flags", {busy_a, done_a, moved_a, win_a}, 0);
        check("abort_score", score_a, 0);
        rst_n = 1'b1;
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            ndone += int'(done_a);
        end
        check("abort_no_done", ndone, 0);
        clr(); bd[0] = 1; bd[1] = 1; bd[2] = 1; bd[3] = 1;
        run_move(1'b0, bd, 2, 1'b0);
        check("post_abort_board", board_out_a, 64'h2200_0000_0000_0000);

        for (int m = 0; m < 40; m++) begin
            clr();
            for (int p = 0; p < 16; p++) bd[p] = rnd_tile();
            run_move(1'b0, bd, m % 4, (m % 5) == 0);
        end
        for (int m = 0; m < 40; m++) begin
            clr();
            for (int p = 0; p < 9; p++) bd[p] = rnd_tile();
            run_move(1'b1, bd, m % 4, (m % 7) == 0);
        end

        check("a_queue_drained", exp_a.size(), 0);
        check("b_queue_drained", exp_b.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end
endmodule
